// File: rtl/color_write_arbiter.sv
// Two-requester round-robin arbiter for the board's single color write port.
// Define LOCK_CHECK_EN to add the lock-ROM lookup stage that refuses writes to fixed clue cells.
module color_write_arbiter #(
  parameter int CELLS   = 81,
  parameter int ADDR_W  = 7,
  parameter int COLOR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [ADDR_W-1:0]  req_addr0,
  input  logic [ADDR_W-1:0]  req_addr1,
  input  logic [COLOR_W-1:0] req_color0,
  input  logic [COLOR_W-1:0] req_color1,
  output logic [ADDR_W-1:0]  lock_addr,
  input  logic               lock_q,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_color,
  output logic [1:0]         ack,
  output logic               rej,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, LOOKUP, DECIDE, ACK} state_t;

  localparam logic [ADDR_W:0] CELLS_L = (ADDR_W+1)'(CELLS);

  state_t                  state;
  logic                    ptr, gnt, gnt_nxt;
  logic [ADDR_W-1:0]       addr_q;
  logic [COLOR_W-1:0]      color_q;
  logic [1:0]              ack_q;
  logic                    rej_q;
  logic                    range_bad, locked, refuse;
  logic [1:0][ADDR_W-1:0]  addr_v;
  logic [1:0][COLOR_W-1:0] color_v;

  assign addr_v  = {req_addr1, req_addr0};
  assign color_v = {req_color1, req_color0};

  // ptr names the requester that wins a tie; a lone request wins outright
  assign gnt_nxt   = (&req) ? ptr : req[1];
  assign range_bad = {1'b0, addr_q} >= CELLS_L;

`ifdef LOCK_CHECK_EN
  localparam state_t POST_GRANT = LOOKUP;
  assign locked    = lock_q;
  assign lock_addr = addr_q;
`else
  localparam state_t POST_GRANT = DECIDE;
  assign locked    = 1'b0 & lock_q;
  assign lock_addr = '0;
`endif

  // lock_q only becomes valid in DECIDE, so the write strobe is decoded from state
  assign refuse   = range_bad | locked;
  assign wr_en    = (state == DECIDE) && !refuse;
  assign wr_addr  = addr_q;
  assign wr_color = color_q;
  assign ack      = ack_q;
  assign rej      = rej_q;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      gnt     <= 1'b0;
      addr_q  <= '0;
      color_q <= '0;
      ack_q   <= '0;
      rej_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= gnt_nxt;
            ptr     <= ~gnt_nxt;
            addr_q  <= addr_v[gnt_nxt];
            color_q <= color_v[gnt_nxt];
            state   <= POST_GRANT;
          end
        end
        LOOKUP: state <= DECIDE;
        DECIDE: begin
          ack_q <= gnt ? 2'b10 : 2'b01;
          rej_q <= refuse;
          state <= ACK;
        end
        ACK: begin
          ack_q <= '0;
          rej_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/color_write_arbiter.md
COLOR_WRITE_ARBITER -- requirements
Module: color_write_arbiter

Interface
REQ-001 SHALL have parameter CELLS, default 81, number of valid board cells.
REQ-002 SHALL have parameter ADDR_W, default 7, cell address width.
REQ-003 SHALL have parameter COLOR_W, default 3, color code width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  2  per-requester write request, held high until its ack.
REQ-007 SHALL have ports req_addr0, req_addr1  input  ADDR_W  target cell per requester.
REQ-008 SHALL have ports req_color0, req_color1  input  COLOR_W  synchronized color per requester.
REQ-009 SHALL have port lock_addr  output  ADDR_W  address to lock ROM (1-cycle read latency).
REQ-010 SHALL have port lock_q  input  1  high = cell is a fixed clue, valid one cycle after lock_addr.
REQ-011 SHALL have ports wr_en (1), wr_addr (ADDR_W), wr_color (COLOR_W)  output  single board write port.
REQ-012 SHALL have port ack  output  2  one-cycle completion pulse to granted requester.
REQ-013 SHALL have port rej  output  1  high with ack when the request was refused.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOOKUP, DECIDE, ACK.
REQ-016 In IDLE with any req bit high, SHALL grant one requester, latch its addr/color, go to LOOKUP next cycle.
REQ-017 Grant SHALL be round-robin: when both request, the requester not granted last wins; after each grant the priority pointer SHALL point to the other requester.
REQ-018 With a single active request, that requester SHALL be granted regardless of the pointer.
REQ-019 In LOOKUP, lock_addr SHALL carry the latched address; SHALL go to DECIDE next cycle.
REQ-020 In DECIDE, a request SHALL be refused if lock_q=1 or latched addr >= CELLS; otherwise wr_en SHALL be 1 for exactly that cycle with wr_addr/wr_color = latched values.
REQ-021 DECIDE SHALL always go to ACK; in ACK, ack[grant] SHALL be 1 for one cycle, rej = refusal result; then IDLE.
REQ-022 Latency: req seen in IDLE at cycle t -> wr_en at t+2 -> ack at t+3; next grant no earlier than t+4.
REQ-023 Requests arriving or changing while busy SHALL be ignored until IDLE; latched addr/color SHALL NOT follow input changes.
REQ-024 wr_en SHALL never assert on a refused request; at most one wr_en per grant.
REQ-025 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-026 Outside LOOKUP, lock_addr SHALL hold the last latched address; outside DECIDE wr_en=0, outside ACK ack=0 and rej=0.

Reset
REQ-027 reset low SHALL immediately force state IDLE, priority pointer to requester 0, wr_en=0, ack=0, rej=0, busy=0, wr_addr=0, wr_color=0, lock_addr=0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no write and no ack; release is taken synchronously on the next clk edge.

Configuration
REQ-029 Macro LOCK_CHECK_EN defined: LOOKUP state and lock check present as above.
REQ-030 LOCK_CHECK_EN undefined: LOOKUP removed, IDLE goes directly to DECIDE, lock_q ignored, lock_addr tied 0, only range check refuses; latency wr_en at t+1, ack at t+2.

Verification
REQ-031 Single req[0], addr=10, color=5, lock_q=0 -> wr_en at t+2 with wr_addr=10, wr_color=5; ack=01, rej=0 at t+3.
REQ-032 req=11 both held from reset -> grants alternate 0,1,0,1 over four transactions, each ack single-cycle.
REQ-033 req[1], addr=4, lock_q=1 -> no wr_en; ack=10 with rej=1 at t+3.
REQ-034 req[0], addr=81 (and 127) -> refused, rej=1, no wr_en, lock state irrelevant.
REQ-035 reset low during DECIDE cycle -> wr_en and busy drop immediately, no ack; after release, pending req granted from requester 0.
REQ-036 Build without LOCK_CHECK_EN, req[0] addr=20 color=3, lock_q=1 -> write at t+1, ack=01 rej=0 at t+2.
